// File: rtl/bp_cce_dir_sharers_reader_if.sv
// Request, directory RAM and sharers-result signals of the directory sharers reader.
// The reader is the slave; the requester/RAM/consumer side uses the master modport.
interface bp_cce_dir_sharers_reader_if #(
  parameter int unsigned num_lce_p     = 8,
  parameter int unsigned lce_assoc_p   = 8,
  parameter int unsigned lce_per_row_p = 2,
  parameter int unsigned tag_width_p   = 20,
  parameter int unsigned wg_width_p    = 6
);
  localparam int unsigned RowsLp  = num_lce_p / lce_per_row_p;
  localparam int unsigned LceW    = $clog2(num_lce_p);
  localparam int unsigned WayW    = $clog2(lce_assoc_p);
  localparam int unsigned RowCntW = $clog2(RowsLp);
  localparam int unsigned EntryW  = tag_width_p + 3;
  localparam int unsigned RowW    = lce_per_row_p * lce_assoc_p * EntryW;

  logic                          r_v_i;
  logic                          r_ready_o;
  logic [wg_width_p-1:0]         r_wg_i;
  logic [tag_width_p-1:0]        r_tag_i;
  logic [LceW-1:0]               lru_lce_i;
  logic [WayW-1:0]               lru_way_i;
  logic                          ram_v_o;
  logic [wg_width_p+RowCntW-1:0] ram_addr_o;
  logic [RowW-1:0]               ram_data_i;
  logic                          sharers_v_o;
  logic [num_lce_p-1:0]          sharers_hits_o;
  logic [num_lce_p*WayW-1:0]     sharers_ways_o;
  logic [num_lce_p*3-1:0]        sharers_coh_states_o;
  logic [2:0]                    lru_coh_state_o;
  logic [tag_width_p-1:0]        lru_tag_o;
  logic                          multi_hit_o;

  modport slave (
    input  r_v_i, r_wg_i, r_tag_i, lru_lce_i, lru_way_i, ram_data_i,
    output r_ready_o, ram_v_o, ram_addr_o, sharers_v_o, sharers_hits_o, sharers_ways_o,
           sharers_coh_states_o, lru_coh_state_o, lru_tag_o, multi_hit_o
  );

  modport master (
    output r_v_i, r_wg_i, r_tag_i, lru_lce_i, lru_way_i, ram_data_i,
    input  r_ready_o, ram_v_o, ram_addr_o, sharers_v_o, sharers_hits_o, sharers_ways_o,
           sharers_coh_states_o, lru_coh_state_o, lru_tag_o, multi_hit_o
  );
endinterface

// File: rtl/bp_cce_dir_sharers_reader.sv
// Reads one directory way-group row by row and consolidates per-LCE tag hits, hit ways and
// coherence states, plus the state/tag of a selected LRU entry.
module bp_cce_dir_sharers_reader #(
  parameter int unsigned num_lce_p     = 8,
  parameter int unsigned lce_assoc_p   = 8,
  parameter int unsigned lce_per_row_p = 2,
  parameter int unsigned tag_width_p   = 20,
  parameter int unsigned wg_width_p    = 6
) (
  input logic                         clk_i,
  input logic                         reset_n_i,
  bp_cce_dir_sharers_reader_if.slave  bus_io
);
  localparam int unsigned RowsLp  = num_lce_p / lce_per_row_p;
  localparam int unsigned LceW    = $clog2(num_lce_p);
  localparam int unsigned WayW    = $clog2(lce_assoc_p);
  localparam int unsigned RowCntW = $clog2(RowsLp);
  localparam int unsigned EntryW  = tag_width_p + 3;
  localparam logic [2:0]  CohI    = 3'd0;

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                    state_q, state_d;
  logic [wg_width_p-1:0]     wg_q, wg_d;
  logic [tag_width_p-1:0]    tag_q, tag_d;
  logic [LceW-1:0]           lru_lce_q, lru_lce_d;
  logic [WayW-1:0]           lru_way_q, lru_way_d;
  logic [RowCntW-1:0]        issue_cnt_q, issue_cnt_d;
  logic [RowCntW-1:0]        data_cnt_q, data_cnt_d;
  logic                      rd_v_q, rd_v_d;
  logic                      sharers_v_q, sharers_v_d;
  logic [num_lce_p-1:0]      hits_q, hits_d;
  logic [num_lce_p*WayW-1:0] ways_q, ways_d;
  logic [num_lce_p*3-1:0]    states_q, states_d;
  logic [2:0]                lru_state_q, lru_state_d;
  logic [tag_width_p-1:0]    lru_tag_q, lru_tag_d;
  logic                      multi_q, multi_d;

  logic [EntryW-1:0]         entry;
  logic [EntryW-1:0]         lru_entry;
  logic                      hit_found;
  logic [WayW-1:0]           hit_way;
  logic [2:0]                hit_state;
  int unsigned               lce_idx;

  always_comb begin
    state_d     = state_q;
    wg_d        = wg_q;
    tag_d       = tag_q;
    lru_lce_d   = lru_lce_q;
    lru_way_d   = lru_way_q;
    issue_cnt_d = issue_cnt_q;
    data_cnt_d  = issue_cnt_q;
    rd_v_d      = 1'b0;
    sharers_v_d = sharers_v_q;
    hits_d      = hits_q;
    ways_d      = ways_q;
    states_d    = states_q;
    lru_state_d = lru_state_q;
    lru_tag_d   = lru_tag_q;
    multi_d     = multi_q;
    entry       = '0;
    lru_entry   = '0;
    hit_found   = 1'b0;
    hit_way     = '0;
    hit_state   = CohI;
    lce_idx     = 0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.r_v_i) begin
          wg_d        = bus_io.r_wg_i;
          tag_d       = bus_io.r_tag_i;
          lru_lce_d   = bus_io.lru_lce_i;
          lru_way_d   = bus_io.lru_way_i;
          issue_cnt_d = '0;
          sharers_v_d = 1'b0;
          hits_d      = '0;
          ways_d      = '0;
          states_d    = '0;
          multi_d     = 1'b0;
          state_d     = StRead;
        end
      end
      StRead: begin
        rd_v_d      = 1'b1;
        issue_cnt_d = issue_cnt_q + RowCntW'(1);
        if (issue_cnt_q == RowCntW'(RowsLp - 1)) state_d = StDrain;
      end
      StDrain: begin
        sharers_v_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Row data returned one cycle after the read; data_cnt_q names the row it belongs to.
    if (rd_v_q) begin
      for (int unsigned l = 0; l < lce_per_row_p; l++) begin
        hit_found = 1'b0;
        hit_way   = '0;
        hit_state = CohI;
        for (int unsigned w = 0; w < lce_assoc_p; w++) begin
          entry = bus_io.ram_data_i[(l * lce_assoc_p + w) * EntryW +: EntryW];
          if (entry[EntryW-1:3] == tag_q && entry[2:0] != CohI) begin
            if (hit_found) begin
              multi_d = 1'b1;
            end else begin
              hit_found = 1'b1;
              hit_way   = WayW'(w);
              hit_state = entry[2:0];
            end
          end
        end
        lce_idx                        = 32'(data_cnt_q) * lce_per_row_p + l;
        hits_d[lce_idx]                = hit_found;
        ways_d[lce_idx * WayW +: WayW] = hit_way;
        states_d[lce_idx * 3 +: 3]     = hit_state;
      end
      if (32'(lru_lce_q) / lce_per_row_p == 32'(data_cnt_q)) begin
        lru_entry = bus_io.ram_data_i[((32'(lru_lce_q) % lce_per_row_p) * lce_assoc_p
                                       + 32'(lru_way_q)) * EntryW +: EntryW];
        lru_state_d = lru_entry[2:0];
        lru_tag_d   = lru_entry[EntryW-1:3];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      wg_q        <= '0;
      tag_q       <= '0;
      lru_lce_q   <= '0;
      lru_way_q   <= '0;
      issue_cnt_q <= '0;
      data_cnt_q  <= '0;
      rd_v_q      <= 1'b0;
      sharers_v_q <= 1'b0;
      hits_q      <= '0;
      ways_q      <= '0;
      states_q    <= '0;
      lru_state_q <= CohI;
      lru_tag_q   <= '0;
      multi_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wg_q        <= wg_d;
      tag_q       <= tag_d;
      lru_lce_q   <= lru_lce_d;
      lru_way_q   <= lru_way_d;
      issue_cnt_q <= issue_cnt_d;
      data_cnt_q  <= data_cnt_d;
      rd_v_q      <= rd_v_d;
      sharers_v_q <= sharers_v_d;
      hits_q      <= hits_d;
      ways_q      <= ways_d;
      states_q    <= states_d;
      lru_state_q <= lru_state_d;
      lru_tag_q   <= lru_tag_d;
      multi_q     <= multi_d;
    end
  end

  assign bus_io.r_ready_o            = (state_q == StIdle);
  assign bus_io.ram_v_o              = (state_q == StRead);
  assign bus_io.ram_addr_o           = {wg_q, issue_cnt_q};
  assign bus_io.sharers_v_o          = sharers_v_q;
  assign bus_io.sharers_hits_o       = hits_q;
  assign bus_io.sharers_ways_o       = ways_q;
  assign bus_io.sharers_coh_states_o = states_q;
  assign bus_io.lru_coh_state_o      = lru_state_q;
  assign bus_io.lru_tag_o            = lru_tag_q;
  assign bus_io.multi_hit_o          = multi_q;

endmodule

// File: tb/tb_bp_cce_dir_sharers_reader.sv
// Directed bench for bp_cce_dir_sharers_reader with a behavioural directory RAM.
module tb_bp_cce_dir_sharers_reader;
  localparam int unsigned EntryW = 23;
  localparam int unsigned RowW   = 2 * 8 * EntryW;
  localparam logic [2:0]  CohS   = 3'd1;
  localparam logic [2:0]  CohE   = 3'd2;
  localparam logic [2:0]  CohM   = 3'd6;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  logic [RowW-1:0] mem [64][4];

  bp_cce_dir_sharers_reader_if bus ();

  bp_cce_dir_sharers_reader dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus_io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_v_o) bus.ram_data_i <= mem[bus.ram_addr_o[7:2]][bus.ram_addr_o[1:0]];
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int wg, input int lce, input int way, input logic [19:0] tag,
                     input logic [2:0] st);
    mem[wg][lce / 2][((lce % 2) * 8 + way) * EntryW +: EntryW] = {tag, st};
  endtask

  // Issues one request (called #1 after an edge with the reader idle) and checks the whole
  // read sequence through to the result cycle T+6.
  task automatic run_req(input logic [5:0] wg, input logic [19:0] tag, input logic [2:0] lce,
                         input logic [2:0] way, input logic poke,
                         input logic [63:0] e_hits, input logic [63:0] e_ways,
                         input logic [63:0] e_states, input logic [2:0] e_lst,
                         input logic [19:0] e_ltag, input logic e_multi);
    check("ready_before", bus.r_ready_o, 1);
    bus.r_v_i     = 1'b1;
    bus.r_wg_i    = wg;
    bus.r_tag_i   = tag;
    bus.lru_lce_i = lce;
    bus.lru_way_i = way;
    step();
    bus.r_v_i = 1'b0;
    check("v_drop_after_accept", bus.sharers_v_o, 0);
    for (int k = 0; k < 4; k++) begin
      if (poke) begin
        bus.r_v_i  = 1'b1;
        bus.r_wg_i = 6'd33;
      end
      check("ram_v_read", bus.ram_v_o, 1);
      check("ram_addr", bus.ram_addr_o, {wg, 2'(k)});
      check("ready_busy", bus.r_ready_o, 0);
      step();
    end
    bus.r_v_i = 1'b0;
    check("ram_v_drain", bus.ram_v_o, 0);
    check("v_drain", bus.sharers_v_o, 0);
    step();
    check("sharers_v", bus.sharers_v_o, 1);
    check("ready_done", bus.r_ready_o, 1);
    check("hits", bus.sharers_hits_o, e_hits);
    check("ways", bus.sharers_ways_o, e_ways);
    check("states", bus.sharers_coh_states_o, e_states);
    check("lru_state", bus.lru_coh_state_o, e_lst);
    check("lru_tag", bus.lru_tag_o, e_ltag);
    check("multi_hit", bus.multi_hit_o, e_multi);
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    reset_n       = 1'b0;
    bus.r_v_i     = 1'b0;
    bus.r_wg_i    = '0;
    bus.r_tag_i   = '0;
    bus.lru_lce_i = '0;
    bus.lru_way_i = '0;
    bus.ram_data_i = '0;
    for (int w = 0; w < 64; w++)
      for (int r = 0; r < 4; r++) mem[w][r] = '0;

    // wg 9: mixed sharers, a stale invalid copy in LCE0, LRU target in LCE6 way5
    put(9, 1, 3, 20'h12345, CohS);
    put(9, 4, 0, 20'h12345, CohM);
    put(9, 6, 5, 20'h54321, CohS);
    put(9, 0, 2, 20'h12345, 3'd0);
    // wg 20: LCE2 hits in two ways, LCE7 hits in its top way
    put(20, 2, 1, 20'h12345, CohS);
    put(20, 2, 6, 20'h12345, CohS);
    put(20, 7, 7, 20'h12345, CohE);

    #2;
    check("rst_ready", bus.r_ready_o, 1);
    check("rst_ram_v", bus.ram_v_o, 0);
    check("rst_sharers_v", bus.sharers_v_o, 0);
    check("rst_hits", bus.sharers_hits_o, 0);
    check("rst_ways", bus.sharers_ways_o, 0);
    check("rst_states", bus.sharers_coh_states_o, 0);
    check("rst_lru_state", bus.lru_coh_state_o, 0);
    check("rst_lru_tag", bus.lru_tag_o, 0);
    check("rst_multi", bus.multi_hit_o, 0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Empty way-group
    run_req(6'd5, 20'h12345, 3'd0, 3'd0, 1'b0, 64'h0, 64'h0, 64'h0, 3'd0, 20'h0, 1'b0);

    // Mixed sharers with LRU capture on a missing LCE
    run_req(6'd9, 20'h12345, 3'd6, 3'd5, 1'b0,
            64'h12, 64'h18, 64'h6008, CohS, 20'h54321, 1'b0);
    for (int i = 0; i < 3; i++) step();
    check("hold_v", bus.sharers_v_o, 1);
    check("hold_hits", bus.sharers_hits_o, 64'h12);
    check("hold_lru_tag", bus.lru_tag_o, 20'h54321);

    // Multi-hit, then back-to-back clean request with r_v_i pulsed while busy
    run_req(6'd20, 20'h12345, 3'd0, 3'd0, 1'b0,
            64'h84, 64'hE00040, 64'h400040, 3'd0, 20'h0, 1'b1);
    run_req(6'd9, 20'h12345, 3'd6, 3'd5, 1'b1,
            64'h12, 64'h18, 64'h6008, CohS, 20'h54321, 1'b0);

    // Reset in the middle of a read
    bus.r_v_i     = 1'b1;
    bus.r_wg_i    = 6'd9;
    bus.r_tag_i   = 20'h12345;
    bus.lru_lce_i = 3'd6;
    bus.lru_way_i = 3'd5;
    step();
    bus.r_v_i = 1'b0;
    step();
    step();
    check("mid_addr_row2", bus.ram_addr_o, {6'd9, 2'd2});
    reset_n = 1'b0;
    #1;
    check("mid_rst_ram_v", bus.ram_v_o, 0);
    check("mid_rst_ready", bus.r_ready_o, 1);
    check("mid_rst_hits", bus.sharers_hits_o, 0);
    check("mid_rst_lru_tag", bus.lru_tag_o, 0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_v_low", bus.sharers_v_o, 0);
    end
    run_req(6'd20, 20'h12345, 3'd0, 3'd0, 1'b0,
            64'h84, 64'hE00040, 64'h400040, 3'd0, 20'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
